// File: rtl/four_demux_reg_pkg.sv
// Shared constants for the four-lane registered demultiplexer.
// Holds the lane count, the 2-bit lane select encodings, the default
// delivered-word counter width and a helper that counts deliveries per cycle.
package four_demux_reg_pkg;

  localparam int NLANES   = 4;
  localparam int CNTW_DEF = 8;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Number of lanes delivering a word this cycle (0..4).
  function automatic logic [2:0] count_dlv(input logic [NLANES-1:0] dlv);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < NLANES; k++) begin
      n = n + {2'b00, dlv[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One lane of the demultiplexer: a single-word data register with valid flag.
// Latency: a write is visible on o_dat/o_vld one cycle later.
// Backpressure: o_rdy = !o_vld | i_rdy, so a lane draining this cycle can be
//   refilled in the same cycle; data is held stable while stalled.
// Ports: clk/rst, i_wr + i_dat (write from the decode), i_rdy (consumer ready),
//   o_dat/o_vld (registered lane output), o_rdy (local ready), o_dlv (delivery).
module demux_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_vld,
  output logic             o_rdy,
  output logic             o_dlv
);

  logic [WIDTH-1:0] r_dat;
  logic             r_vld;
  logic             w_acc;

  assign o_dat = r_dat;
  assign o_vld = r_vld;
  assign o_dlv = r_vld & i_rdy;
  assign o_rdy = ~r_vld | i_rdy;
  // Guard against a write into a full, stalled slot even if the caller
  // did not qualify it with o_rdy.
  assign w_acc = i_wr & o_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dat <= '0;
      r_vld <= 1'b0;
    end else if (w_acc) begin
      // Covers both a fill from empty and a refill while delivering.
      r_dat <= i_dat;
      r_vld <= 1'b1;
    end else if (o_dlv) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/four_demux_reg.sv
// Routes one input word to one of four registered output lanes selected by s.
// Latency: 1 cycle from accept to lane valid.
// Backpressure: ir reflects only the selected lane, so a stalled lane never
//   blocks traffic to the others; cnt counts words delivered on all lanes.
// Ports: clk/rst, i/s/iv/ir (input handshake), o0..o3/v0..v3/r0..r3 (lanes),
//   cnt (delivered-word counter, wraps modulo 2^CNTW).
module four_demux_reg
  import four_demux_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       s,
  input  logic             iv,
  output logic             ir,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNTW-1:0]  cnt
);

  logic [NLANES-1:0] w_wr;
  logic [NLANES-1:0] w_lrdy;
  logic [NLANES-1:0] w_rdy;
  logic [NLANES-1:0] w_vld;
  logic [NLANES-1:0] w_dlv;
  logic [WIDTH-1:0]  w_dat [NLANES];
  logic [2:0]        w_ndlv;
  logic [CNTW-1:0]   r_cnt;

  assign w_lrdy = {r3, r2, r1, r0};

  // Ready select mux: only the addressed lane matters.
  always_comb begin
    ir = 1'b0;
    case (s)
      LANE0:   ir = w_rdy[0];
      LANE1:   ir = w_rdy[1];
      LANE2:   ir = w_rdy[2];
      LANE3:   ir = w_rdy[3];
      default: ir = 1'b0;
    endcase
  end

  // 2-to-4 write decode, qualified by the input handshake.
  always_comb begin
    w_wr = '0;
    if (iv && ir) begin
      case (s)
        LANE0:   w_wr[0] = 1'b1;
        LANE1:   w_wr[1] = 1'b1;
        LANE2:   w_wr[2] = 1'b1;
        LANE3:   w_wr[3] = 1'b1;
        default: w_wr    = '0;
      endcase
    end
  end

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .i_wr  (w_wr[k]),
      .i_dat (i),
      .i_rdy (w_lrdy[k]),
      .o_dat (w_dat[k]),
      .o_vld (w_vld[k]),
      .o_rdy (w_rdy[k]),
      .o_dlv (w_dlv[k])
    );
  end

  assign o0 = w_dat[0];
  assign o1 = w_dat[1];
  assign o2 = w_dat[2];
  assign o3 = w_dat[3];
  assign v0 = w_vld[0];
  assign v1 = w_vld[1];
  assign v2 = w_vld[2];
  assign v3 = w_vld[3];

  assign w_ndlv = count_dlv(w_dlv);

  // Wraps naturally at 2^CNTW; no saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNTW'(w_ndlv);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: tb/tb_four_demux_reg.sv
// Directed bench for four_demux_reg (WIDTH=1, CNTW=8).
// Inputs change on the falling edge, outputs are checked on the next falling
// edge; combinational ir is checked 1 ns after inputs settle.
module tb_four_demux_reg;

  logic       clk;
  logic       rst;
  logic [0:0] i;
  logic [1:0] s;
  logic       iv;
  logic       ir;
  logic [0:0] o0, o1, o2, o3;
  logic       v0, v1, v2, v3;
  logic       r0, r1, r2, r3;
  logic [7:0] cnt;

  int n_checks;
  int n_fail;

  four_demux_reg #(
    .WIDTH (1),
    .CNTW  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .s   (s),
    .iv  (iv),
    .ir  (ir),
    .o0  (o0),
    .o1  (o1),
    .o2  (o2),
    .o3  (o3),
    .v0  (v0),
    .v1  (v1),
    .v2  (v2),
    .v3  (v3),
    .r0  (r0),
    .r1  (r1),
    .r2  (r2),
    .r3  (r3),
    .cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then return to the falling edge for checking/driving.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Write one word into lane sel (lane must be able to accept).
  task automatic push(input logic [1:0] sel, input logic d);
    s  = sel;
    i  = d;
    iv = 1'b1;
    cycle();
    iv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv  = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_v: got %b want 0000", {v3, v2, v1, v0});
    end
    n_checks++;
    if ({o3, o2, o1, o0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_o: got %b want 0000", {o3, o2, o1, o0});
    end
    n_checks++;
    if (cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", cnt);
    end
    rst = 1'b0;
    cycle();
    // Ready for every lane right after reset, regardless of consumer ready.
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      #1;
      n_checks++;
      if (ir !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ir_s%0d: got %b want 1", k, ir);
      end
    end
  endtask

  task automatic test_single_accept();
    push(2'd2, 1'b1);
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b0100 || o2 !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_lane2: v=%b o2=%b want v=0100 o2=1", {v3, v2, v1, v0}, o2);
    end
    s  = 2'd2;
    i  = 1'b0;
    iv = 1'b1;
    #1;
    n_checks++;
    if (ir !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_ir: got %b want 0", ir);
    end
    cycle();
    iv = 1'b0;
    n_checks++;
    if (o2 !== 1'b1 || v2 !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: o2=%b v2=%b want 1 1", o2, v2);
    end
  endtask

  task automatic test_other_lane();
    s  = 2'd0;
    i  = 1'b1;
    iv = 1'b1;
    #1;
    n_checks++;
    if (ir !== 1'b1) begin
      n_fail++;
      $display("FAIL other_ir: got %b want 1", ir);
    end
    cycle();
    iv = 1'b0;
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b0101 || o0 !== 1'b1 || o2 !== 1'b1) begin
      n_fail++;
      $display("FAIL other_lane: v=%b o0=%b o2=%b want 0101 1 1", {v3, v2, v1, v0}, o0, o2);
    end
    r0 = 1'b1;
    r2 = 1'b1;
    cycle();
    r0 = 1'b0;
    r2 = 1'b0;
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b0000 || cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL drain_two: v=%b cnt=%0d want 0000 2", {v3, v2, v1, v0}, cnt);
    end
  endtask

  task automatic test_same_cycle_refill();
    push(2'd1, 1'b1);
    s  = 2'd1;
    i  = 1'b0;
    iv = 1'b1;
    r1 = 1'b1;
    #1;
    n_checks++;
    if (ir !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_ir: got %b want 1", ir);
    end
    cycle();
    iv = 1'b0;
    n_checks++;
    if (v1 !== 1'b1 || o1 !== 1'b0 || cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL refill: v1=%b o1=%b cnt=%0d want 1 0 3", v1, o1, cnt);
    end
    cycle();
    r1 = 1'b0;
    n_checks++;
    if (v1 !== 1'b0 || cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL refill_drain: v1=%b cnt=%0d want 0 4", v1, cnt);
    end
  endtask

  task automatic test_all_drain();
    push(2'd0, 1'b1);
    push(2'd1, 1'b0);
    push(2'd2, 1'b1);
    push(2'd3, 1'b0);
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b1111 || {o3, o2, o1, o0} !== 4'b0101) begin
      n_fail++;
      $display("FAIL fill_all: v=%b o=%b want 1111 0101", {v3, v2, v1, v0}, {o3, o2, o1, o0});
    end
    {r3, r2, r1, r0} = 4'b1111;
    cycle();
    {r3, r2, r1, r0} = 4'b0000;
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b0000 || cnt !== 8'd8) begin
      n_fail++;
      $display("FAIL drain_all: v=%b cnt=%0d want 0000 8", {v3, v2, v1, v0}, cnt);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    // 254 cycles of streaming through lane 0 give 253 deliveries; one more
    // drain cycle brings the total to 254.
    s  = 2'd0;
    i  = 1'b1;
    r0 = 1'b1;
    iv = 1'b1;
    for (int n = 0; n < 254; n++) cycle();
    iv = 1'b0;
    cycle();
    r0 = 1'b0;
    n_checks++;
    if (cnt !== 8'd254 || v0 !== 1'b0) begin
      n_fail++;
      $display("FAIL preset_254: cnt=%0d v0=%b want 254 0", cnt, v0);
    end
    push(2'd0, 1'b1);
    push(2'd1, 1'b1);
    push(2'd2, 1'b1);
    {r2, r1, r0} = 3'b111;
    cycle();
    {r2, r1, r0} = 3'b000;
    n_checks++;
    if (cnt !== 8'd1 || {v3, v2, v1, v0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap: cnt=%0d v=%b want 1 0000", cnt, {v3, v2, v1, v0});
    end
  endtask

  task automatic test_reset_priority();
    push(2'd0, 1'b1);
    push(2'd3, 1'b1);
    rst = 1'b1;
    s   = 2'd1;
    i   = 1'b1;
    iv  = 1'b1;
    r0  = 1'b1;
    r3  = 1'b1;
    cycle();
    rst = 1'b0;
    iv  = 1'b0;
    r0  = 1'b0;
    r3  = 1'b0;
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b0000 || {o3, o2, o1, o0} !== 4'b0000 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_priority: v=%b o=%b cnt=%0d want 0000 0000 0",
               {v3, v2, v1, v0}, {o3, o2, o1, o0}, cnt);
    end
    cycle();
    n_checks++;
    if (v1 !== 1'b0 || o1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_lane1_empty: v1=%b o1=%b want 0 0", v1, o1);
    end
    push(2'd3, 1'b1);
    n_checks++;
    if ({v3, v2, v1, v0} !== 4'b1000 || o3 !== 1'b1 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL post_rst_accept: v=%b o3=%b cnt=%0d want 1000 1 0",
               {v3, v2, v1, v0}, o3, cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    i   = 1'b0;
    s   = 2'd0;
    iv  = 1'b0;
    {r3, r2, r1, r0} = 4'b0000;
    test_reset();
    test_single_accept();
    test_other_lane();
    test_same_cycle_refill();
    test_all_drain();
    test_wrap();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
